// File: rtl/crank_phase_interp_pkg.sv
// Shared crank-angle constants and the phase type used by the tooth decoder,
// the phase interpolator and the ignition/injection schedulers.
package crank_pkg;

  // Quanta per nominal tooth; the decoder advances eng_phase by this much per tooth.
  localparam int QPT = 256;
  // Phase width in quanta.
  localparam int PW  = 16;
  // Tooth period width in clk cycles.
  localparam int TW  = 32;

  typedef logic [PW-1:0] phase_t;

endpackage

// File: rtl/crank_phase_interp_phase_dda.sv
// Phase DDA: between tooth edges, adds QPT to an accumulator every clk and
// steps the phase by one quantum each time the accumulator covers the last
// tooth period. This gives 256/tooth_period quanta per clk. The phase never
// passes the last quantum of the current tooth (cap).
module phase_dda
  import crank_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_load,
  input  logic          i_step_en,
  input  phase_t        i_eng_phase,
  input  phase_t        i_next_len,
  input  logic [TW-1:0] i_period,
  output phase_t        o_phase,
  output logic          o_step,
  output logic          o_rate_limited
);

  localparam logic [TW:0]   QPT_EXT = (TW+1)'(QPT);
  localparam logic [TW-1:0] QPT_TW  = TW'(QPT);

  logic [TW-1:0] r_acc;
  logic [TW-1:0] r_period;
  phase_t        r_phase;
  phase_t        r_cap;
  logic          r_rate_limited;

  logic [TW:0]   w_acc_next;
  logic [TW:0]   w_period_ext;
  logic [TW:0]   w_acc_rem;
  logic          w_reach;
  logic          w_below_cap;

  // One bit wider than acc so that the add cannot wrap before the compare.
  assign w_acc_next   = {1'b0, r_acc} + QPT_EXT;
  assign w_period_ext = {1'b0, r_period};
  assign w_acc_rem    = w_acc_next - w_period_ext;
  assign w_reach      = (w_acc_next >= w_period_ext);
  assign w_below_cap  = (r_phase < r_cap);

  // A zero period would step every clk, so it is treated as "no rate known".
  assign o_step = i_step_en && (r_period != '0) && w_reach && w_below_cap;

  // Tooth-edge load, then accumulate and step the phase between edges.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_acc          <= '0;
      r_period       <= '0;
      r_phase        <= '0;
      r_cap          <= '0;
      r_rate_limited <= 1'b0;
    end else if (i_load) begin
      r_period       <= i_period;
      r_phase        <= i_eng_phase;
      r_cap          <= i_eng_phase + i_next_len - phase_t'(1);
      r_acc          <= '0;
      r_rate_limited <= (i_period < QPT_TW);
    end else if (i_step_en) begin
      if (o_step) begin
        r_phase <= r_phase + phase_t'(1);
        r_acc   <= w_acc_rem[TW-1:0];
      end else if (w_reach) begin
        // Parked at cap (or zero period): keep acc from growing without bound.
        r_acc   <= r_period;
      end else begin
        r_acc   <= w_acc_next[TW-1:0];
      end
    end
  end

  assign o_phase        = r_phase;
  assign o_rate_limited = r_rate_limited;

endmodule

// File: rtl/crank_phase_interp.sv
// Crank phase interpolator: fine-grained engine phase between decoder tooth
// edges plus a single-shot angle-match pulse for the schedulers. The DDA
// sub-module does the stepping; this level owns validity, snap classification
// at tooth edges and the match/arming logic.
module crank_phase_interp
  import crank_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          trigger,
  input  logic          synced,
  input  phase_t        eng_phase,
  input  phase_t        next_tooth_len,
  input  logic [TW-1:0] tooth_period,
  input  phase_t        match_angle,
  input  logic          match_en,
  output phase_t        phase,
  output logic          phase_valid,
  output logic          match,
  output logic          rate_limited
);

  logic   r_base_seen;
  logic   r_phase_valid;
  logic   r_match;
  logic   r_armed;
  phase_t r_ma_prev;

  logic   w_trig;
  logic   w_step_en;
  logic   w_step;
  logic   w_base_next;
  logic   w_eval;
  logic   w_ma_chg;
  logic   w_fire;
  logic   w_wrap;
  logic   w_rate_limited;
  phase_t w_phase;
  phase_t w_phase_inc;

  // Edges are only meaningful while the decoder is in sync.
  assign w_trig      = trigger && synced;
  // Losing sync freezes the phase immediately, not one clk later.
  assign w_step_en   = r_phase_valid && synced && !w_trig;
  assign w_base_next = synced && (r_base_seen || w_trig);
  assign w_eval      = match_en && r_armed && synced;
  assign w_ma_chg    = (match_angle != r_ma_prev);
  assign w_phase_inc = w_phase + phase_t'(1);

  phase_dda u_dda (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_load         (w_trig),
    .i_step_en      (w_step_en),
    .i_eng_phase    (eng_phase),
    .i_next_len     (next_tooth_len),
    .i_period       (tooth_period),
    .o_phase        (w_phase),
    .o_step         (w_step),
    .o_rate_limited (w_rate_limited)
  );

  // Classify the phase movement of this clk and decide whether it sweeps over match_angle.
  always_comb begin
    w_fire = 1'b0;
    w_wrap = 1'b0;
    if (w_trig) begin
      if (!r_phase_valid) begin
        // First edge after (re)sync: the old phase is stale, only an exact hit counts.
        w_fire = w_eval && (match_angle == eng_phase);
      end else if (eng_phase > w_phase) begin
        w_fire = w_eval && (match_angle > w_phase) && (match_angle <= eng_phase);
      end else if (eng_phase < w_phase) begin
        // New engine cycle: the swept range runs to the top of phase and from zero.
        w_wrap = 1'b1;
        w_fire = w_eval && ((match_angle > w_phase) || (match_angle <= eng_phase));
      end
    end else if (w_step) begin
      w_fire = w_eval && (w_phase_inc == match_angle);
    end
  end

  // Validity, registered match pulse and one-shot arming.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_base_seen   <= 1'b0;
      r_phase_valid <= 1'b0;
      r_match       <= 1'b0;
      r_armed       <= 1'b1;
      r_ma_prev     <= '0;
    end else begin
      r_base_seen   <= w_base_next;
      r_phase_valid <= w_base_next;
      r_match       <= w_fire;
      r_ma_prev     <= match_angle;
      if (w_fire) begin
        r_armed <= 1'b0;
      end else if (w_wrap || w_ma_chg) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign phase        = w_phase;
  assign phase_valid  = r_phase_valid;
  assign match        = r_match;
  assign rate_limited = w_rate_limited;

endmodule

// File: tb/tb_crank_phase_interp.sv
// Bench for crank_phase_interp: directed tooth scenarios followed by random
// tooth streams, all compared every clk against a closed-form angle model.
module tb_crank_phase_interp;
  import crank_pkg::*;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          trigger;
  logic          synced;
  phase_t        eng_phase;
  phase_t        next_tooth_len;
  logic [TW-1:0] tooth_period;
  phase_t        match_angle;
  logic          match_en;
  phase_t        phase;
  logic          phase_valid;
  logic          match;
  logic          rate_limited;

  int n_checks = 0;
  int n_err    = 0;

  // Reference state: phase after a tooth edge is E + elapsed*QPT/P, clipped at the tooth's last quantum.
  longint m_E, m_C, m_P, m_t;
  int     m_phase;
  int     m_ma_prev;
  bit     m_valid, m_seen, m_rl, m_match, m_armed;

  always #5 clk = ~clk;

  crank_phase_interp dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .trigger        (trigger),
    .synced         (synced),
    .eng_phase      (eng_phase),
    .next_tooth_len (next_tooth_len),
    .tooth_period   (tooth_period),
    .match_angle    (match_angle),
    .match_en       (match_en),
    .phase          (phase),
    .phase_valid    (phase_valid),
    .match          (match),
    .rate_limited   (rate_limited)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit     acc, fire, wrap, eval;
    int     old, nw, ma, e;
    longint steps, tgt;
    if (!reset_n) begin
      m_E = 0; m_C = 0; m_P = 0; m_t = 0;
      m_phase = 0; m_ma_prev = 0;
      m_valid = 0; m_seen = 0; m_rl = 0; m_match = 0; m_armed = 1;
      return;
    end
    ma   = int'(match_angle);
    e    = int'(eng_phase);
    acc  = trigger && synced;
    old  = m_phase;
    nw   = old;
    fire = 0;
    wrap = 0;
    eval = match_en && m_armed && synced;
    if (acc) begin
      m_E  = longint'(e);
      m_P  = longint'(tooth_period);
      m_C  = longint'(e) + longint'(next_tooth_len) - 1;
      m_t  = 0;
      m_rl = (m_P < 256);
      nw   = e;
      if (!m_valid)    fire = eval && (ma == e);
      else if (e > old) fire = eval && (ma > old) && (ma <= e);
      else if (e < old) begin
        wrap = 1;
        fire = eval && ((ma > old) || (ma <= e));
      end
    end else if (m_valid && synced) begin
      m_t++;
      if (m_P == 0)        steps = 0;
      else if (m_P < 256)  steps = m_t;
      else                 steps = (m_t * 256) / m_P;
      tgt  = m_E + steps;
      if (tgt > m_C) tgt = m_C;
      nw   = int'(tgt);
      fire = eval && (nw != old) && (nw == ma);
    end
    if (fire)                         m_armed = 0;
    else if (wrap || ma != m_ma_prev) m_armed = 1;
    m_ma_prev = ma;
    m_seen    = synced && (m_seen || acc);
    m_valid   = m_seen;
    m_phase   = nw;
    m_match   = fire;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("phase", 32'(phase), 32'(m_phase));
    chk("phase_valid", 32'(phase_valid), 32'(m_valid));
    chk("match", 32'(match), 32'(m_match));
    chk("rate_limited", 32'(rate_limited), 32'(m_rl));
    trigger = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic trig(input int e, input int len, input int per);
    eng_phase      = phase_t'(e);
    next_tooth_len = phase_t'(len);
    tooth_period   = TW'(per);
    trigger        = 1'b1;
    tick();
  endtask

  initial begin
    int first, cnt, gap, drop, e, len, r;
    reset_n = 1'b0; trigger = 1'b0; synced = 1'b0; match_en = 1'b0;
    eng_phase = '0; next_tooth_len = '0; tooth_period = '0; match_angle = '0;
    @(negedge clk);
    run(3);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_valid", 32'(phase_valid), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_rl", 32'(rate_limited), 32'd0);
    reset_n = 1'b1; synced = 1'b1;
    run(2);
    chk("no_edge_invalid", 32'(phase_valid), 32'd0);

    // Nominal tooth: 4 clks per quantum, holds at the tooth's last quantum.
    trig(512, 256, 1024);
    chk("A_first", 32'(phase), 32'd512);
    chk("A_valid", 32'(phase_valid), 32'd1);
    run(1019); chk("A_766", 32'(phase), 32'd766);
    run(1);    chk("A_767", 32'(phase), 32'd767);
    run(50);   chk("A_hold", 32'(phase), 32'd767);

    // Missing-tooth gap then wrap to the start of the engine cycle.
    trig(14592, 768, 1024);
    run(3067); chk("MT_15358", 32'(phase), 32'd15358);
    run(1);    chk("MT_15359", 32'(phase), 32'd15359);
    run(20);   chk("MT_hold", 32'(phase), 32'd15359);
    trig(0, 256, 1024);
    chk("MT_wrap", 32'(phase), 32'd0);

    // Increment match: one pulse at N+177, re-armed only by the next engine cycle.
    match_angle = 300; match_en = 1'b1;
    trig(256, 256, 1024);
    first = -1; cnt = 0;
    for (int k = 1; k <= 400; k++) begin
      tick();
      if (match) begin
        cnt++;
        if (first < 0) first = k + 1;
      end
    end
    chk("M_at", 32'(first), 32'd177);
    chk("M_cnt", 32'(cnt), 32'd1);
    trig(512, 256, 1024);
    trig(0, 256, 1024);
    trig(256, 256, 1024);
    cnt = 0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (match) cnt++;
    end
    chk("M_second", 32'(cnt), 32'd1);

    // Forward snap over the compare angle.
    match_en = 1'b0; match_angle = 260;
    trig(256, 256, 1024);
    match_en = 1'b1;
    run(5);
    trig(512, 256, 1024);
    chk("FS_match", 32'(match), 32'd1);
    run(1);
    chk("FS_once", 32'(match), 32'd0);

    // Sync loss mid-tooth freezes the phase; validity returns after an edge.
    trig(0, 256, 1024);
    run(49); chk("SD_pre", 32'(phase), 32'd12);
    synced = 1'b0;
    tick();  chk("SD_valid", 32'(phase_valid), 32'd0);
    run(20); chk("SD_frozen", 32'(phase), 32'd12);
    chk("SD_nomatch", 32'(match), 32'd0);
    synced = 1'b1;
    run(3);  chk("SD_wait", 32'(phase_valid), 32'd0);
    trig(0, 256, 1024);
    chk("SD_resync", 32'(phase_valid), 32'd1);
    chk("SD_phase", 32'(phase), 32'd0);

    // Teeth faster than QPT clks: one quantum per clk, flagged.
    trig(1024, 256, 200);
    chk("RL_set", 32'(rate_limited), 32'd1);
    run(10);  chk("RL_step", 32'(phase), 32'd1034);
    run(300); chk("RL_cap", 32'(phase), 32'd1279);
    trig(1280, 256, 2000);
    chk("RL_clear", 32'(rate_limited), 32'd0);

    // Reset in the middle of a rate-limited tooth.
    trig(1536, 256, 100);
    run(30);
    reset_n = 1'b0;
    tick();
    chk("R2_phase", 32'(phase), 32'd0);
    chk("R2_valid", 32'(phase_valid), 32'd0);
    chk("R2_rl", 32'(rate_limited), 32'd0);
    reset_n = 1'b1;
    tick();

    // Zero period: no advance.
    trig(0, 256, 0);
    run(50);
    chk("P0_hold", 32'(phase), 32'd0);

    // Random tooth streams with sync dropouts and moving compare angles.
    gap = 0; drop = 0;
    for (int i = 0; i < 5000; i++) begin
      if (drop > 0) drop--;
      else if ($urandom_range(0, 299) == 0) drop = $urandom_range(1, 8);
      synced = (drop == 0);
      if ($urandom_range(0, 49) == 0)
        match_angle = phase_t'(m_phase + $urandom_range(0, 60));
      if ($urandom_range(0, 99) == 0)
        match_en = ($urandom_range(0, 3) != 0);
      if (gap == 0) begin
        gap = $urandom_range(1, 500);
        r   = $urandom_range(0, 9);
        if (r == 0)      e = m_phase;
        else if (r <= 5) e = (m_phase + $urandom_range(1, 400)) % 65536;
        else             e = $urandom_range(0, 65535);
        len = $urandom_range(1, (65536 - e < 1024) ? 65536 - e : 1024);
        r   = $urandom_range(0, 9);
        eng_phase      = phase_t'(e);
        next_tooth_len = phase_t'(len);
        if (r == 0)      tooth_period = '0;
        else if (r <= 2) tooth_period = TW'($urandom_range(1, 255));
        else             tooth_period = TW'($urandom_range(256, 3000));
        trigger = 1'b1;
      end else begin
        gap--;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/crank_phase_interp.md
Name: crank_phase_interp

Overview:
- Sits directly downstream of the crank tooth decoder (trigger/synced/eng_phase/next_tooth_length_deg/tooth_period producer).
- Decoder gives engine phase only at tooth edges (256 quanta per tooth). This block interpolates a fine-grained phase between edges with a DDA running at 256/tooth_period quanta per clk.
- Also fires a single-shot angle-match pulse for the ignition/injection schedulers.

Parameters:
- QPT, 256, quanta per nominal tooth; must equal the decoder's per-tooth increment.
- PW, 16, phase width in quanta.
- TW, 32, tooth period width in clk cycles.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- trigger  in  1  one-clk pulse per accepted tooth edge while decoder synced
- synced  in  1  decoder sync status
- eng_phase  in  PW  phase of the tooth just accepted; valid in the trigger cycle
- next_tooth_len  in  PW  angular length in quanta of the tooth now starting; valid in the trigger cycle
- tooth_period  in  TW  clk cycles of the last nominal (QPT) tooth; valid in the trigger cycle
- match_angle  in  PW  compare angle
- match_en  in  1  arm compare
- phase  out  PW  interpolated phase
- phase_valid  out  1  phase is trustworthy
- match  out  1  one-clk pulse on reaching match_angle
- rate_limited  out  1  tooth_period < QPT; interpolation cannot keep pace

Behaviour:
- Reset: phase=0, phase_valid=0, match=0, rate_limited=0, acc=0, cap=0, base_seen=0, armed=1.
- Trigger in cycle N (trigger=1 and synced=1):
  - Latch period_r=tooth_period.
  - phase<=eng_phase.
  - cap<=eng_phase+next_tooth_len-1 (PW-bit add; the decoder guarantees no overflow).
  - acc<=0, base_seen<=1, rate_limited<=(tooth_period<QPT).
  - Phase is visible at N+1.
- Between triggers (phase_valid=1, no trigger):
  - acc_next=acc+QPT, computed TW+1 bits wide.
  - If acc_next>=period_r and phase<cap: phase<=phase+1, acc<=acc_next-period_r.
  - Otherwise acc<=acc_next, saturating at period_r.
  - At most one phase increment per clk.
  - phase never exceeds cap; it holds at cap until the next trigger.
- Period 0 guard: if period_r==0, phase does not advance.
- phase_valid=synced & base_seen, registered.
  - synced low: phase_valid<=0 and base_seen<=0 in the next cycle. phase and acc freeze and match is suppressed.
  - After resync, phase_valid first goes high the cycle after the first trigger.
- Match rules, evaluated only when phase_valid=1, match_en=1 and armed=1:
  - Increment step: fire when the new phase==match_angle.
  - Forward snap (eng_phase>old phase): fire if old<match_angle<=eng_phase.
  - Wrap snap (eng_phase<old phase): fire if match_angle>old or match_angle<=eng_phase.
  - Snap with eng_phase==old phase: no fire unless this cycle is the first valid phase and match_angle==eng_phase.
- match is registered and asserts the cycle phase shows the matching value. Firing clears armed.
- armed is set on every wrap snap and on any match_angle change. At most one match per engine cycle per angle.
- Trigger while synced=0 is ignored.
- Reset mid-tooth returns all state to the reset values.

Decomposition:
- Shared package crank_pkg holds QPT, PW and TW, plus a phase_t typedef reused by the decoder and the schedulers.
- Sub-module phase_dda holds acc, period_r, cap and phase stepping. The top level holds validity, the snap logic and the match/arming logic.
- No further hierarchy.

Test Plan:
- tooth_period=1024, next_tooth_len=256, trigger with eng_phase=512:
  - phase=512 at N+1.
  - Phase increments once every 4 clks.
  - Phase holds at 767 from N+1021 until the next trigger.
- Missing-tooth case: tooth_period=1024, next_tooth_len=768, eng_phase=14592:
  - Phase climbs 4 clks per quantum to 15359, then holds.
  - Next trigger with eng_phase=0 snaps phase to 0 (wrap).
- match_angle=300, match_en=1, trigger at N with eng_phase=256, period=1024:
  - match is a single pulse in the cycle phase==300, i.e. N+177.
  - No second pulse before wrap; a second pulse occurs in the next engine cycle.
- match_angle=260, trigger eng_phase=256 then trigger eng_phase=512 with period=1024 (match_en raised after the first trigger):
  - Forward snap over 260 fires match in the snap cycle.
- synced drops mid-tooth:
  - phase_valid=0 next cycle, phase frozen, no match.
  - Resync plus trigger eng_phase=0 gives phase_valid=1 at trigger+1.
- tooth_period=200:
  - rate_limited=1, phase steps 1/clk up to cap.
  - Next trigger with period=2000 clears rate_limited.
